arb_req_stage: RTL

- Upstream feeder for the 4-way request/grant arbiter.
- Collects transaction requests from N clients as single-cycle push pulses and keeps a pending count per client.
- Drives the arbiter's req vector and consumes its gnt vector.
- Owns the shared resource for a fixed burst after each accepted grant, then re-arbitrates.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_pend_ctr.sv | 38 +++
 rtl/arb_req_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter request stage.
package arb_pkg;
   localparam int N_REQ = 4;
   localparam int CNT_W = 3;

   typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

   // OR of set-bit indices; exact when vec is one-hot.
   function automatic logic [$clog2(N_REQ)-1:0] onehot_idx(input logic [N_REQ-1:0] vec);
      logic [$clog2(N_REQ)-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i]) idx = idx | i[$clog2(N_REQ)-1:0];
      end
      return idx;
   endfunction
endpackage

// File: rtl/arb_pend_ctr.sv
// Per-client pending counter: saturating up/down with sticky overflow.
module arb_pend_ctr #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (inc && !dec) begin
         if (cnt_q == '1) ovf_d = 1'b1;
         else             cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;
endmodule

// File: rtl/arb_req_stage.sv
// Request feeder for the 4-way arbiter: pending counts, req/gnt handshake, fixed bursts.
// Optional stat_xfers/stat_busy counters are built when ARB_REQ_STATS_EN is defined.
//
// state | meaning
// ARB   | req driven from non-zero pending counts, waiting for a valid grant
// XFER  | owning the resource for BURST beats, req forced low
module arb_req_stage #(
   parameter int N     = arb_pkg::N_REQ,
   parameter int CNT_W = arb_pkg::CNT_W,
   parameter int BURST = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         push,
   input  logic [N-1:0]         gnt,
   output logic [N-1:0]         req,
   output logic [N*CNT_W-1:0]   pend_cnt,
   output logic                 xfer_valid,
   output logic [$clog2(N)-1:0] xfer_id,
   output logic                 xfer_last,
   output logic [N-1:0]         ovf,
   output logic                 gnt_err
`ifdef ARB_REQ_STATS_EN
   ,
   output logic [15:0]          stat_xfers,
   output logic [15:0]          stat_busy
`endif
);
   import arb_pkg::*;

   localparam int ID_W   = $clog2(N);
   localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [ID_W-1:0]   xfer_id_q, xfer_id_d;
   logic              gnt_err_q, gnt_err_d;
   logic [N-1:0]      cnt_nz;
   logic              accept, bad_gnt, last_beat;

   // A grant is taken only if it is one-hot and lands on a requesting client.
   always_comb begin
      accept  = (state_q == ARB) && $onehot(gnt) && ((gnt & req) != '0);
      bad_gnt = (state_q == ARB) && (gnt != '0) && !accept;
   end

   for (genvar i = 0; i < N; i++) begin : g_pend
      arb_pend_ctr #(.CNT_W(CNT_W)) u_ctr (
         .clk (clk),
         .rst (rst),
         .inc (push[i]),
         .dec (accept && gnt[i]),
         .cnt (pend_cnt[i*CNT_W +: CNT_W]),
         .ovf (ovf[i])
      );
      assign cnt_nz[i] = (pend_cnt[i*CNT_W +: CNT_W] != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ARB;
         beat_q    <= '0;
         xfer_id_q <= '0;
         gnt_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         xfer_id_q <= xfer_id_d;
         gnt_err_q <= gnt_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      xfer_id_d = xfer_id_q;
      gnt_err_d = gnt_err_q | bad_gnt;
      case (state_q)
         ARB: begin
            beat_d = '0;
            if (accept) begin
               state_d   = XFER;
               xfer_id_d = onehot_idx(gnt);
            end
         end
         XFER: begin
            if (last_beat) begin
               state_d = ARB;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      last_beat  = (state_q == XFER) && (beat_q == LAST_BEAT);
      xfer_valid = (state_q == XFER);
      xfer_last  = last_beat;
      xfer_id    = xfer_id_q;
      gnt_err    = gnt_err_q;
      req        = (state_q == ARB) ? cnt_nz : '0;
   end

`ifdef ARB_REQ_STATS_EN
   logic [15:0] stat_xfers_q, stat_xfers_d;
   logic [15:0] stat_busy_q, stat_busy_d;

   always_comb begin
      stat_xfers_d = stat_xfers_q + {15'd0, accept};
      stat_busy_d  = stat_busy_q + {15'd0, (state_q == XFER)};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_xfers_q <= '0;
         stat_busy_q  <= '0;
      end else begin
         stat_xfers_q <= stat_xfers_d;
         stat_busy_q  <= stat_busy_d;
      end
   end

   assign stat_xfers = stat_xfers_q;
   assign stat_busy  = stat_busy_q;
`endif
endmodule
